// File: rtl/sync_fifo_v2_if.sv
// sync_fifo_v2_if: handshake/data bundle for sync_fifo_v2.
//   master : producer/consumer side; drives din, wr_en, rd_en and observes status.
//   slave  : FIFO side; drives dout, dout_valid, count, level flags and the
//            sticky overflow/underflow error flags.
interface sync_fifo_v2_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LOG2_DEPTH = 3
);
  logic [DATA_WIDTH-1:0] din;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [LOG2_DEPTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output din, wr_en, rd_en,
    input  dout, dout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  din, wr_en, rd_en,
    output dout, dout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_v2.sv
// sync_fifo_v2: single-clock FIFO, DEPTH = 2**LOG2_DEPTH entries.
//   clk      : clock, all state on rising edge
//   reset_n  : asynchronous active-low reset
//   clr      : synchronous flush (also clears overflow/underflow)
//   f        : sync_fifo_v2_if.slave (din/wr_en/rd_en in; dout, dout_valid,
//              full, empty, almost_full, almost_empty, count, overflow,
//              underflow out)
// FWFT=0: dout registered, dout_valid pulses for one cycle per accepted read.
// FWFT=1: dout shows the head word combinationally; rd_en acknowledges it.
module sync_fifo_v2 #(
  parameter int DATA_WIDTH = 8,
  parameter int LOG2_DEPTH = 3,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = (1 << LOG2_DEPTH) - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  sync_fifo_v2_if.slave     f
);
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int CW    = LOG2_DEPTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         cnt;
  logic                  ovf, unf;
  logic                  is_empty, is_full;
  logic                  rd_acc, wr_acc;

  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == CW'(DEPTH));

  // clr wins over both requests; a write into a full FIFO rides on a
  // same-cycle accepted read, a read from an empty FIFO never succeeds.
  assign rd_acc = f.rd_en & ~is_empty & ~clr;
  assign wr_acc = f.wr_en & (~is_full | rd_acc) & ~clr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (f.wr_en & ~wr_acc) ovf <= 1'b1;
      if (f.rd_en & ~rd_acc) unf <= 1'b1;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= f.din;
  end

  generate
    if (FWFT != 0) begin : gen_fwft
      assign f.dout       = is_empty ? '0 : mem[rd_ptr];
      assign f.dout_valid = ~is_empty;
    end else begin : gen_std
      logic [DATA_WIDTH-1:0] dout_r;
      logic                  dv_r;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          dout_r <= '0;
          dv_r   <= 1'b0;
        end else if (clr) begin
          dout_r <= '0;
          dv_r   <= 1'b0;
        end else begin
          dv_r <= rd_acc;
          if (rd_acc) dout_r <= mem[rd_ptr];
        end
      end
      assign f.dout       = dout_r;
      assign f.dout_valid = dv_r;
    end
  endgenerate

  assign f.count        = cnt;
  assign f.full         = is_full;
  assign f.empty        = is_empty;
  assign f.almost_full  = (cnt >= CW'(AF_THRESH));
  assign f.almost_empty = (cnt <= CW'(AE_THRESH));
  assign f.overflow     = ovf;
  assign f.underflow    = unf;
endmodule

// File: tb/tb_sync_fifo_v2.sv
// tb_sync_fifo_v2: scoreboard bench for sync_fifo_v2.
//   u_std  : default depth 8, standard registered read
//   u_fwft : depth 8, first-word-fall-through
// Writes push the expected word into a queue; standard-mode dout_valid pulses
// and FWFT acknowledges pop and compare against it.
module tb_sync_fifo_v2;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_v2_if #(.DATA_WIDTH(8), .LOG2_DEPTH(3)) f0 ();
  sync_fifo_v2_if #(.DATA_WIDTH(8), .LOG2_DEPTH(3)) f1 ();

  sync_fifo_v2 #(.DATA_WIDTH(8), .LOG2_DEPTH(3), .FWFT(0)) u_std (
    .clk(clk), .reset_n(reset_n), .clr(clr), .f(f0.slave));
  sync_fifo_v2 #(.DATA_WIDTH(8), .LOG2_DEPTH(3), .FWFT(1)) u_fwft (
    .clk(clk), .reset_n(reset_n), .clr(clr), .f(f1.slave));

  int checks = 0;
  int failures = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int m0 = 0, m1 = 0;          // model occupancy
  bit mov = 0, mun = 0;        // model sticky flags (standard instance)
  int exp_pulses = 0, got_pulses = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Standard-mode scoreboard pop: dout_valid is high for exactly one cycle.
  always @(negedge clk) begin
    if (f0.dout_valid === 1'b1) begin
      got_pulses++;
      if (q0.size() == 0) chk("dout_unexpected", {24'd0, f0.dout}, 32'hdead);
      else chk("dout", {24'd0, f0.dout}, {24'd0, q0.pop_front()});
    end
  end

  task automatic chk_std();
    chk("count",  32'(f0.count), 32'(m0));
    chk("full",   32'(f0.full), 32'(m0 == 8));
    chk("empty",  32'(f0.empty), 32'(m0 == 0));
    chk("afull",  32'(f0.almost_full), 32'(m0 >= 6));
    chk("aempty", 32'(f0.almost_empty), 32'(m0 <= 2));
    chk("ovf",    32'(f0.overflow), 32'(mov));
    chk("unf",    32'(f0.underflow), 32'(mun));
  endtask

  task automatic step0(input bit wr, input bit rd, input logic [7:0] d);
    bit racc, wacc;
    racc = rd && (m0 != 0);
    wacc = wr && ((m0 != 8) || racc);
    if (wacc) q0.push_back(d);
    if (racc) exp_pulses++;
    if (wr && !wacc) mov = 1;
    if (rd && !racc) mun = 1;
    m0 = m0 + int'(wacc) - int'(racc);
    f0.wr_en = wr; f0.rd_en = rd; f0.din = d;
    @(posedge clk); #1;
    f0.wr_en = 0; f0.rd_en = 0;
    chk_std();
  endtask

  task automatic step1(input bit wr, input bit rd, input logic [7:0] d);
    bit racc, wacc;
    racc = rd && (m1 != 0);
    wacc = wr && ((m1 != 8) || racc);
    if (racc) chk("fwft_head", {24'd0, f1.dout}, {24'd0, q1.pop_front()});
    if (wacc) q1.push_back(d);
    m1 = m1 + int'(wacc) - int'(racc);
    f1.wr_en = wr; f1.rd_en = rd; f1.din = d;
    @(posedge clk); #1;
    f1.wr_en = 0; f1.rd_en = 0;
    chk("fwft_count", 32'(f1.count), 32'(m1));
    chk("fwft_dv", 32'(f1.dout_valid), 32'(m1 != 0));
    if (m1 == 0) chk("fwft_dout_empty", {24'd0, f1.dout}, 32'd0);
    else chk("fwft_dout", {24'd0, f1.dout}, {24'd0, q1[0]});
  endtask

  initial begin
    f0.wr_en = 0; f0.rd_en = 0; f0.din = '0;
    f1.wr_en = 0; f1.rd_en = 0; f1.din = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    chk_std();
    chk("rst_dout", {24'd0, f0.dout}, 32'd0);
    chk("rst_dv", 32'(f0.dout_valid), 32'd0);

    // fill 0x01..0x08, then overflow attempt
    for (int i = 1; i <= 8; i++) step0(1, 0, 8'(i));
    step0(1, 0, 8'hFF);
    // drain in order
    for (int i = 0; i < 8; i++) step0(0, 1, 8'h00);
    @(negedge clk); #1;
    // read when empty: rejected, dout holds last word
    step0(0, 1, 8'h00);
    chk("dout_hold", {24'd0, f0.dout}, 32'h08);
    chk("dv_low", 32'(f0.dout_valid), 32'd0);
    // simultaneous read+write when empty
    step0(1, 1, 8'hAA);
    step0(0, 1, 8'h00);
    // full with simultaneous read+write of 0x55
    for (int i = 0; i < 8; i++) step0(1, 0, 8'(8'h30 + i));
    step0(1, 1, 8'h55);
    for (int i = 0; i < 8; i++) step0(0, 1, 8'h00);
    @(negedge clk); #1;
    chk("last_out", {24'd0, f0.dout}, 32'h55);
    // pointer wrap with 20 write/read pairs at occupancy 1
    step0(1, 0, 8'hC0);
    for (int i = 1; i <= 20; i++) step0(1, 1, 8'(8'hC0 + i));
    step0(0, 1, 8'h00);
    @(negedge clk); #1;
    chk("pulses", 32'(got_pulses), 32'(exp_pulses));
    chk("q_drained", 32'(q0.size()), 32'd0);

    // FWFT instance
    step1(1, 0, 8'h11);
    chk("fwft_first", {24'd0, f1.dout}, 32'h11);
    step1(1, 0, 8'h22);
    step1(0, 1, 8'h00);
    chk("fwft_second", {24'd0, f1.dout}, 32'h22);
    step1(0, 1, 8'h00);
    chk("fwft_empty", 32'(f1.empty), 32'd1);

    // clr with count=5, overflow=1 and a concurrent write
    for (int i = 0; i < 5; i++) step0(1, 0, 8'(8'h60 + i));
    chk("pre_clr_ovf", 32'(f0.overflow), 32'd1);
    f0.wr_en = 1; f0.din = 8'hEE; clr = 1;
    @(posedge clk); #1;
    clr = 0; f0.wr_en = 0;
    m0 = 0; mov = 0; mun = 0; q0.delete();
    chk_std();

    // async reset mid-cycle
    for (int i = 0; i < 3; i++) step0(1, 0, 8'(8'h70 + i));
    step0(0, 1, 8'h00);
    #2 reset_n = 1'b0;
    #1;
    m0 = 0; mov = 0; mun = 0; q0.delete();
    chk_std();
    chk("arst_dout", {24'd0, f0.dout}, 32'd0);
    chk("arst_dv", 32'(f0.dout_valid), 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    step0(1, 0, 8'h9A);
    step0(0, 1, 8'h00);
    @(negedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
